// File: rtl/mole_height_animator_if.sv
// mole_height_animator_if
//   Bundles the game-core controls and the display-side outputs of the mole
//   height animator. The game core / testbench drives the master side; the
//   animator is the slave.
//   pause     : freezes prescaler and all channels
//   mole_up   : per-hole "mole should be up" level
//   hit       : per-hole single-cycle hammer strobe
//   heights   : packed per-hole heights, hole i at [i*H_W +: H_W]
//   hit_flag  : per-hole stunned indication (HOLD or KNOCK)
//   moving    : per-hole animation-in-progress (RISE, FALL or KNOCK)
//   tick      : exported animation tick
interface mole_height_animator_if #(
    parameter int N_MOLES = 12,
    parameter int H_W     = 6
);
    logic                     pause;
    logic [N_MOLES-1:0]       mole_up;
    logic [N_MOLES-1:0]       hit;
    logic [N_MOLES*H_W-1:0]   heights;
    logic [N_MOLES-1:0]       hit_flag;
    logic [N_MOLES-1:0]       moving;
    logic                     tick;

    modport master (output pause, mole_up, hit,
                    input  heights, hit_flag, moving, tick);
    modport slave  (input  pause, mole_up, hit,
                    output heights, hit_flag, moving, tick);
endinterface

// File: rtl/mole_height_animator.sv
// mole_height_animator
//   Per-hole pop-up height animation for the whack-a-mole display path.
//   A shared prescaler produces one animation tick every TICK_DIV clocks
//   (frozen while pause is high); each hole runs an independent FSM
//   (DOWN/RISE/UP/FALL plus a hit knockdown HOLD/KNOCK) that steps its
//   height only on ticks. Hits are accepted on any unpaused clock.
//   Ports: clk, reset (async, active low), bus (slave side of
//   mole_height_animator_if; see that file for the signal list).
//   All outputs are registered. The exported tick is the registered copy
//   of the internal tick, so it rises together with the heights that tick
//   produced.

module mole_height_channel #(
    parameter int H_W      = 6,
    parameter int H_MAX    = 40,
    parameter int HIT_HOLD = 8,
    parameter int HIT_STEP = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           pause,
    input  logic           mole_up,
    input  logic           hit,
    output logic [H_W-1:0] height,
    output logic           hit_flag,
    output logic           moving
);
    typedef enum logic [2:0] {DOWN, RISE, UP, FALL, HOLD, KNOCK} state_t;

    localparam int             HC_W = $clog2(HIT_HOLD + 1);
    localparam logic [H_W-1:0] HMAX = H_W'(H_MAX);
    localparam logic [H_W-1:0] ONE  = H_W'(1);

    state_t          state, state_n;
    logic [H_W-1:0]  height_n;
    logic            armed, armed_n;
    logic [HC_W-1:0] hold_cnt, hold_n;
    logic            hit_ok;

    // Only a visible, animating mole can be struck; pause drops the strobe.
    assign hit_ok = hit && !pause && (height != '0) &&
                    (state == RISE || state == UP || state == FALL);

    always_comb begin
        state_n  = state;
        height_n = height;
        armed_n  = armed;
        hold_n   = hold_cnt;
        if (hit_ok) begin
            // Hit wins over a coincident tick: no height step, no hold count.
            state_n = HOLD;
            hold_n  = '0;
        end else if (tick) begin
            unique case (state)
                DOWN: begin
                    if (mole_up && armed) begin
                        state_n  = RISE;
                        height_n = ONE;
                    end else if (!mole_up) begin
                        armed_n = 1'b1;
                    end
                end
                RISE, FALL: begin
                    if (mole_up) begin
                        height_n = height + ONE;
                        state_n  = (height == HMAX - ONE) ? UP : RISE;
                    end else begin
                        height_n = height - ONE;
                        state_n  = (height == ONE) ? DOWN : FALL;
                    end
                end
                UP: begin
                    if (!mole_up) begin
                        state_n  = FALL;
                        height_n = HMAX - ONE;
                    end
                end
                HOLD: begin
                    hold_n = hold_cnt + 1'b1;
                    if (hold_cnt == HC_W'(HIT_HOLD - 1)) state_n = KNOCK;
                end
                KNOCK: begin
                    // Compare in H_W+1 bits so the last step clamps at 0.
                    if ({1'b0, height} <= (H_W+1)'(HIT_STEP)) begin
                        height_n = '0;
                        state_n  = DOWN;
                        armed_n  = 1'b0;
                    end else begin
                        height_n = height - H_W'(HIT_STEP);
                    end
                end
                default: state_n = DOWN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= DOWN;
            height   <= '0;
            armed    <= 1'b1;
            hold_cnt <= '0;
            hit_flag <= 1'b0;
            moving   <= 1'b0;
        end else begin
            state    <= state_n;
            height   <= height_n;
            armed    <= armed_n;
            hold_cnt <= hold_n;
            hit_flag <= (state_n == HOLD) || (state_n == KNOCK);
            moving   <= (state_n == RISE) || (state_n == FALL) || (state_n == KNOCK);
        end
    end
endmodule

module mole_height_animator #(
    parameter int N_MOLES  = 12,
    parameter int H_W      = 6,
    parameter int H_MAX    = 40,
    parameter int TICK_DIV = 131072,
    parameter int HIT_HOLD = 8,
    parameter int HIT_STEP = 2
) (
    input logic                   clk,
    input logic                   reset,
    mole_height_animator_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0]              div_cnt;
    logic                          tick_int;
    logic [N_MOLES-1:0][H_W-1:0]   h_arr;
    logic [N_MOLES-1:0]            flag_arr;
    logic [N_MOLES-1:0]            mov_arr;

    assign tick_int = (div_cnt == CNT_W'(TICK_DIV - 1)) && !bus.pause;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            bus.tick <= 1'b0;
        end else begin
            bus.tick <= tick_int;
            if (!bus.pause) div_cnt <= tick_int ? '0 : div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_MOLES; i++) begin : g_ch
        mole_height_channel #(
            .H_W(H_W), .H_MAX(H_MAX), .HIT_HOLD(HIT_HOLD), .HIT_STEP(HIT_STEP)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick_int),
            .pause    (bus.pause),
            .mole_up  (bus.mole_up[i]),
            .hit      (bus.hit[i]),
            .height   (h_arr[i]),
            .hit_flag (flag_arr[i]),
            .moving   (mov_arr[i])
        );
    end

    assign bus.heights  = h_arr;
    assign bus.hit_flag = flag_arr;
    assign bus.moving   = mov_arr;
endmodule

// File: tb/tb_mole_height_animator.sv
module tb_mole_height_animator;
    localparam int N  = 12;
    localparam int HW = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mole_height_animator_if #(.N_MOLES(N), .H_W(HW)) bus ();
    mole_height_animator_if #(.N_MOLES(1), .H_W(HW)) bus2 ();

    mole_height_animator #(.N_MOLES(N), .H_W(HW), .H_MAX(40), .TICK_DIV(4),
                           .HIT_HOLD(8), .HIT_STEP(2))
        dut (.clk(clk), .reset(reset), .bus(bus));

    mole_height_animator #(.N_MOLES(1), .H_W(HW), .H_MAX(40), .TICK_DIV(4),
                           .HIT_HOLD(8), .HIT_STEP(3))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hgt(input int i);
        hgt = 32'(bus.heights[i*HW +: HW]);
    endfunction

    function automatic logic tk(input bit second);
        tk = second ? bus2.tick : bus.tick;
    endfunction

    task automatic wait_tick(input bit second);
        int n;
        step();
        n = 1;
        while (!tk(second) && n < 10) begin
            step();
            n++;
        end
        if (!tk(second)) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout observed=0 expected=1");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.pause = 1'b0;  bus.mole_up = '0;  bus.hit = '0;
        bus2.pause = 1'b0; bus2.mole_up = '0; bus2.hit = '0;

        // Reset state
        repeat (3) step();
        chk("rst_heights", {31'b0, bus.heights == '0}, 1);
        chk("rst_hit_flag", {31'b0, bus.hit_flag == '0}, 1);
        chk("rst_moving", {31'b0, bus.moving == '0}, 1);
        chk("rst_tick", {31'b0, bus.tick}, 0);
        reset = 1'b1;

        // Tick period
        wait_tick(0);
        n = 0;
        do begin step(); n++; end while (!bus.tick && n < 10);
        chk("tick_period", n, 4);

        // Rise / fall on channel 0
        bus.mole_up[0] = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            wait_tick(0);
            chk("rise_h0", hgt(0), (t > 40) ? 40 : t);
            if (t == 20) chk("rise_moving0", {31'b0, bus.moving[0]}, 1);
            if (t == 40) chk("up_moving0", {31'b0, bus.moving[0]}, 0);
        end
        bus.mole_up[0] = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            wait_tick(0);
            chk("fall_h0", hgt(0), 40 - t);
        end
        chk("down_moving0", {31'b0, bus.moving[0]}, 0);

        // Reversal on channel 3
        bus.mole_up[3] = 1'b1;
        for (int t = 1; t <= 10; t++) begin wait_tick(0); chk("rev_up_h3", hgt(3), t); end
        bus.mole_up[3] = 1'b0;
        for (int t = 1; t <= 4; t++) begin wait_tick(0); chk("rev_dn_h3", hgt(3), 10 - t); end
        bus.mole_up[3] = 1'b1;
        for (int t = 1; t <= 3; t++) begin wait_tick(0); chk("rev_re_h3", hgt(3), 6 + t); end
        bus.mole_up[3] = 1'b0;

        // Knockdown on channel 5
        bus.mole_up[5] = 1'b1;
        repeat (40) wait_tick(0);
        chk("knock_pre_h5", hgt(5), 40);
        bus.hit[5] = 1'b1;
        step();
        bus.hit[5] = 1'b0;
        chk("hit_flag5", {31'b0, bus.hit_flag[5]}, 1);
        chk("hold_moving5", {31'b0, bus.moving[5]}, 0);
        for (int t = 1; t <= 8; t++) begin
            wait_tick(0);
            chk("hold_h5", hgt(5), 40);
            if (t == 7) chk("hold7_moving5", {31'b0, bus.moving[5]}, 0);
            if (t == 8) chk("knock_moving5", {31'b0, bus.moving[5]}, 1);
        end
        for (int t = 1; t <= 20; t++) begin
            wait_tick(0);
            chk("knock_h5", hgt(5), 40 - 2 * t);
        end
        chk("knock_done_flag5", {31'b0, bus.hit_flag[5]}, 0);
        for (int t = 1; t <= 3; t++) begin wait_tick(0); chk("disarmed_h5", hgt(5), 0); end
        bus.mole_up[5] = 1'b0;
        wait_tick(0);
        chk("rearm_low_h5", hgt(5), 0);
        bus.mole_up[5] = 1'b1;
        wait_tick(0);
        chk("rearm_h5", hgt(5), 1);
        bus.mole_up[5] = 1'b0;

        // Hit coinciding with a tick on channel 2
        bus.mole_up[2] = 1'b1;
        repeat (17) wait_tick(0);
        chk("coll_pre_h2", hgt(2), 17);
        step(); step(); step();
        bus.hit[2] = 1'b1;
        step();
        bus.hit[2] = 1'b0;
        chk("coll_tick", {31'b0, bus.tick}, 1);
        chk("coll_h2", hgt(2), 17);
        chk("coll_flag2", {31'b0, bus.hit_flag[2]}, 1);
        for (int t = 1; t <= 8; t++) begin
            wait_tick(0);
            chk("coll_hold_h2", hgt(2), 17);
            if (t == 7) chk("coll_hold7_moving2", {31'b0, bus.moving[2]}, 0);
            if (t == 8) chk("coll_knock_moving2", {31'b0, bus.moving[2]}, 1);
        end
        wait_tick(0);
        chk("coll_knock_h2", hgt(2), 15);
        bus.mole_up[2] = 1'b0;

        // Hit on an empty hole
        bus.hit[7] = 1'b1;
        step();
        bus.hit[7] = 1'b0;
        chk("idle_hit_flag7", {31'b0, bus.hit_flag[7]}, 0);

        // Pause mid-rise on channel 8
        bus.mole_up[8] = 1'b1;
        repeat (5) wait_tick(0);
        chk("pause_pre_h8", hgt(8), 5);
        step(); step();
        bus.pause = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.hit[8] = (c == 5);
            step();
            chk("pause_tick", {31'b0, bus.tick}, 0);
            chk("pause_h8", hgt(8), 5);
        end
        bus.hit[8] = 1'b0;
        chk("pause_hit_flag8", {31'b0, bus.hit_flag[8]}, 0);
        bus.pause = 1'b0;
        step();
        chk("resume_early_tick", {31'b0, bus.tick}, 0);
        step();
        chk("resume_tick", {31'b0, bus.tick}, 1);
        chk("resume_h8", hgt(8), 6);
        bus.mole_up[8] = 1'b0;

        // Reset during KNOCK on channel 11
        bus.mole_up[11] = 1'b1;
        repeat (10) wait_tick(0);
        bus.hit[11] = 1'b1;
        step();
        bus.hit[11] = 1'b0;
        repeat (9) wait_tick(0);
        chk("knock_h11", hgt(11), 8);
        chk("knock_flag11", {31'b0, bus.hit_flag[11]}, 1);
        reset = 1'b0;
        step();
        chk("rst_mid_heights", {31'b0, bus.heights == '0}, 1);
        chk("rst_mid_hit_flag", {31'b0, bus.hit_flag == '0}, 1);
        chk("rst_mid_moving", {31'b0, bus.moving == '0}, 1);
        chk("rst_mid_tick", {31'b0, bus.tick}, 0);
        bus.mole_up = '0;
        reset = 1'b1;

        // HIT_STEP = 3 clamps from h = 1 to 0
        bus2.mole_up[0] = 1'b1;
        repeat (40) wait_tick(1);
        chk("d2_pre_h", 32'(bus2.heights), 40);
        bus2.hit[0] = 1'b1;
        step();
        bus2.hit[0] = 1'b0;
        repeat (8) wait_tick(1);
        for (int t = 1; t <= 14; t++) begin
            wait_tick(1);
            chk("d2_knock_h", 32'(bus2.heights), (t < 14) ? 40 - 3 * t : 0);
        end
        chk("d2_done_flag", {31'b0, bus2.hit_flag[0]}, 0);
        bus2.mole_up[0] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
